// File: rtl/decode_stage.sv
// Registered RV32I decode stage: decodes opcode/control fields of a fetched
// instruction, holds one decoded instruction for execute, and stalls one
// cycle on load-use hazards against the instruction it currently holds.
module decode_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic        in_ready,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [2:0]  out_imm_type,
    output logic [4:0]  out_rd,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [2:0]  out_funct3,
    output logic        out_reg_write,
    output logic        out_mem_read,
    output logic        out_mem_write,
    output logic        out_branch,
    output logic        out_jump,
    output logic        out_alu_src,
    output logic        out_illegal
);

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    logic [2:0] dec_imm_type;
    logic       dec_reg_write, dec_mem_read, dec_mem_write;
    logic       dec_branch, dec_jump, dec_alu_src, dec_illegal;
    logic       dec_uses_rs1, dec_uses_rs2;

    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [2:0]  imm_type_q, imm_type_d;
    logic        reg_write_q, reg_write_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic        branch_q, branch_d;
    logic        jump_q, jump_d;
    logic        alu_src_q, alu_src_d;
    logic        illegal_q, illegal_d;

    logic hazard;
    logic accept;

    // Decode the incoming instruction word into control bits and register usage.
    always_comb begin
        dec_imm_type  = IMM_I;
        dec_reg_write = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_branch    = 1'b0;
        dec_jump      = 1'b0;
        dec_alu_src   = 1'b0;
        dec_illegal   = 1'b0;
        dec_uses_rs1  = 1'b0;
        dec_uses_rs2  = 1'b0;
        case (in_instr[6:0])
            7'b0110111, 7'b0010111: begin   // LUI, AUIPC
                dec_imm_type  = IMM_U;
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
            end
            7'b1101111: begin               // JAL
                dec_imm_type  = IMM_J;
                dec_reg_write = 1'b1;
                dec_jump      = 1'b1;
                dec_alu_src   = 1'b1;
            end
            7'b1100111: begin               // JALR
                dec_reg_write = 1'b1;
                dec_jump      = 1'b1;
                dec_alu_src   = 1'b1;
                dec_uses_rs1  = 1'b1;
            end
            7'b1100011: begin               // BRANCH
                dec_imm_type  = IMM_B;
                dec_branch    = 1'b1;
                dec_uses_rs1  = 1'b1;
                dec_uses_rs2  = 1'b1;
            end
            7'b0000011: begin               // LOAD
                dec_reg_write = 1'b1;
                dec_mem_read  = 1'b1;
                dec_alu_src   = 1'b1;
                dec_uses_rs1  = 1'b1;
            end
            7'b0100011: begin               // STORE
                dec_imm_type  = IMM_S;
                dec_mem_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_uses_rs1  = 1'b1;
                dec_uses_rs2  = 1'b1;
            end
            7'b0010011: begin               // OP-IMM
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_uses_rs1  = 1'b1;
            end
            7'b0110011: begin               // OP
                dec_reg_write = 1'b1;
                dec_uses_rs1  = 1'b1;
                dec_uses_rs2  = 1'b1;
            end
            7'b1110011: begin               // SYSTEM
                dec_alu_src   = 1'b1;
                dec_uses_rs1  = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
        // Writes to x0 are architecturally discarded.
        if (in_instr[11:7] == 5'd0) dec_reg_write = 1'b0;
    end

    // Load-use hazard against the held load, and the resulting accept handshake.
    always_comb begin
        hazard = valid_q & mem_read_q & (instr_q[11:7] != 5'd0) & in_valid &
                 ((dec_uses_rs1 & (in_instr[19:15] == instr_q[11:7])) |
                  (dec_uses_rs2 & (in_instr[24:20] == instr_q[11:7])));
        in_ready = ~flush & ~hazard & (~valid_q | out_ready);
        accept   = in_valid & in_ready;
    end

    // Next-state for the output register: flush > accept > drain > hold.
    always_comb begin
        valid_d     = valid_q;
        instr_d     = instr_q;
        pc_d        = pc_q;
        imm_type_d  = imm_type_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        branch_d    = branch_q;
        jump_d      = jump_q;
        alu_src_d   = alu_src_q;
        illegal_d   = illegal_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d     = 1'b1;
            instr_d     = in_instr;
            pc_d        = in_pc;
            imm_type_d  = dec_imm_type;
            reg_write_d = dec_reg_write;
            mem_read_d  = dec_mem_read;
            mem_write_d = dec_mem_write;
            branch_d    = dec_branch;
            jump_d      = dec_jump;
            alu_src_d   = dec_alu_src;
            illegal_d   = dec_illegal;
        end else if (out_ready && valid_q) begin
            valid_d = 1'b0;
        end
    end

    // Output register, cleared asynchronously so a reset drops the held instruction at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b0;
            instr_q     <= '0;
            pc_q        <= '0;
            imm_type_q  <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            branch_q    <= 1'b0;
            jump_q      <= 1'b0;
            alu_src_q   <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            instr_q     <= instr_d;
            pc_q        <= pc_d;
            imm_type_q  <= imm_type_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            branch_q    <= branch_d;
            jump_q      <= jump_d;
            alu_src_q   <= alu_src_d;
            illegal_q   <= illegal_d;
        end
    end

    assign out_valid     = valid_q;
    assign out_instr     = instr_q;
    assign out_pc        = pc_q;
    assign out_imm_type  = imm_type_q;
    assign out_rd        = instr_q[11:7];
    assign out_rs1       = instr_q[19:15];
    assign out_rs2       = instr_q[24:20];
    assign out_funct3    = instr_q[14:12];
    assign out_reg_write = reg_write_q;
    assign out_mem_read  = mem_read_q;
    assign out_mem_write = mem_write_q;
    assign out_branch    = branch_q;
    assign out_jump      = jump_q;
    assign out_alu_src   = alu_src_q;
    assign out_illegal   = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage with hand-computed expectations.
module tb_decode_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [2:0]  out_imm_type;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_funct3;
    logic        out_reg_write, out_mem_read, out_mem_write;
    logic        out_branch, out_jump, out_alu_src, out_illegal;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [31:0] ADDI1  = 32'h0050_0093;  // addi x1, x0, 5
    localparam logic [31:0] ADDI2  = 32'h00A0_0113;  // addi x2, x0, 10
    localparam logic [31:0] SW     = 32'h0011_2223;
    localparam logic [31:0] BEQ    = 32'h0020_8463;
    localparam logic [31:0] JAL    = 32'h0080_00EF;
    localparam logic [31:0] LUI    = 32'h1234_52B7;
    localparam logic [31:0] LW     = 32'h0000_A283;  // lw x5, 0(x1)
    localparam logic [31:0] ADD_D  = 32'h0022_8333;  // add x6, x5, x2
    localparam logic [31:0] ADD_ND = 32'h0023_8333;  // add x6, x7, x2
    localparam logic [31:0] ILL    = 32'h0000_007F;
    localparam logic [31:0] NOP0   = 32'h0000_0013;  // addi x0, x0, 0

    decode_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_ready(in_ready),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .out_imm_type(out_imm_type),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct3(out_funct3),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_branch(out_branch), .out_jump(out_jump),
        .out_alu_src(out_alu_src), .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Advance one clock: return 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Control bits packed {reg_write, mem_read, mem_write, branch, jump, alu_src}
    function automatic logic [31:0] ctrl();
        return {26'd0, out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump, out_alu_src};
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b1;
        #1;
        check("reset_valid", {31'd0, out_valid}, 32'd0);
        check("reset_instr", out_instr, 32'd0);
        cyc(); cyc();

        // Single ADDI
        rst = 1'b0; in_valid = 1'b1; in_instr = ADDI1; in_pc = 32'h0000_0040;
        #1;
        check("rel_in_ready", {31'd0, in_ready}, 32'd1);
        cyc();
        in_valid = 1'b0;
        check("addi_valid", {31'd0, out_valid}, 32'd1);
        check("addi_imm", {29'd0, out_imm_type}, 32'd0);
        check("addi_rd", {27'd0, out_rd}, 32'd1);
        check("addi_ctrl", ctrl(), 32'b100001);
        check("addi_instr", out_instr, ADDI1);
        check("addi_pc", out_pc, 32'h0000_0040);
        cyc();
        check("drain_valid", {31'd0, out_valid}, 32'd0);

        // Back-to-back stream
        in_valid = 1'b1; in_instr = SW;
        cyc();
        in_instr = BEQ;
        check("sw_imm", {29'd0, out_imm_type}, 32'd1);
        check("sw_ctrl", ctrl(), 32'b001001);
        check("sw_fields", {17'd0, out_funct3, out_rs1, out_rs2}, {17'd0, 3'd2, 5'd2, 5'd1});
        cyc();
        in_instr = JAL;
        check("beq_imm", {29'd0, out_imm_type}, 32'd2);
        check("beq_ctrl", ctrl(), 32'b000100);
        cyc();
        in_instr = LUI;
        check("jal_imm", {29'd0, out_imm_type}, 32'd4);
        check("jal_ctrl", ctrl(), 32'b100011);
        cyc();
        in_valid = 1'b0;
        check("lui_imm", {29'd0, out_imm_type}, 32'd3);
        check("lui_ctrl", ctrl(), 32'b100001);
        check("lui_rd", {27'd0, out_rd}, 32'd5);
        check("lui_valid", {31'd0, out_valid}, 32'd1);
        cyc();

        // Backpressure
        out_ready = 1'b0; in_valid = 1'b1; in_instr = ADDI1; in_pc = 32'h100;
        cyc();
        in_instr = ADDI2; in_pc = 32'h104;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_instr", out_instr, ADDI1);
            check("bp_pc", out_pc, 32'h100);
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            cyc();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        cyc();
        in_valid = 1'b0;
        check("bp_next_instr", out_instr, ADDI2);
        check("bp_next_pc", out_pc, 32'h104);
        cyc();

        // Load-use with dependency: exactly one bubble
        in_valid = 1'b1; in_instr = LW;
        cyc();
        in_instr = ADD_D;
        check("lw_memread", {31'd0, out_mem_read}, 32'd1);
        #1;
        check("lu_hazard_ready", {31'd0, in_ready}, 32'd0);
        cyc();
        check("lu_bubble", {31'd0, out_valid}, 32'd0);
        check("lu_after_ready", {31'd0, in_ready}, 32'd1);
        cyc();
        in_valid = 1'b0;
        check("lu_add_valid", {31'd0, out_valid}, 32'd1);
        check("lu_add_instr", out_instr, ADD_D);
        check("add_ctrl", ctrl(), 32'b100000);
        cyc();

        // Load followed by independent ADD: no bubble
        in_valid = 1'b1; in_instr = LW;
        cyc();
        in_instr = ADD_ND;
        #1;
        check("nohz_ready", {31'd0, in_ready}, 32'd1);
        cyc();
        in_valid = 1'b0;
        check("nohz_valid", {31'd0, out_valid}, 32'd1);
        check("nohz_instr", out_instr, ADD_ND);
        cyc();

        // Flush while holding with incoming instruction
        out_ready = 1'b0; in_valid = 1'b1; in_instr = ADDI1;
        cyc();
        check("fl_hold_valid", {31'd0, out_valid}, 32'd1);
        flush = 1'b1; in_instr = ADDI2;
        #1;
        check("fl_in_ready", {31'd0, in_ready}, 32'd0);
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        cyc();
        check("fl_never_out", {31'd0, out_valid}, 32'd0);

        // Illegal opcode and rd = x0
        in_valid = 1'b1; in_instr = ILL;
        cyc();
        in_instr = NOP0;
        check("ill_flag", {31'd0, out_illegal}, 32'd1);
        check("ill_ctrl", ctrl(), 32'd0);
        check("ill_imm", {29'd0, out_imm_type}, 32'd0);
        cyc();
        in_valid = 1'b0;
        check("x0_illegal", {31'd0, out_illegal}, 32'd0);
        check("x0_ctrl", ctrl(), 32'b000001);
        cyc();

        // Asynchronous reset between clock edges
        out_ready = 1'b0; in_valid = 1'b1; in_instr = ADDI1;
        cyc();
        in_valid = 1'b0;
        check("ar_pre_valid", {31'd0, out_valid}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("ar_valid", {31'd0, out_valid}, 32'd0);
        check("ar_instr", out_instr, 32'd0);
        rst = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
